// File: rtl/bfedp_pkg.sv
// bfedp_pkg: shared widths, default pipeline depth and FSM state type for the bFEDP sequencer
package bfedp_pkg;
    localparam int PIPE_LAT_DEF = 3;
    localparam int ACT_W = 64;
    localparam int WCOL_W = 8;
    localparam int SHIFT_W = 12;
    localparam int PSUM_W = 16;
    localparam int STEP_W = 5;
    localparam int COLS = 4;
    localparam int LANES = ACT_W / 8;
    localparam int SH_W = SHIFT_W / COLS;
    localparam int WAIT_W = 3;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/bfedp_seq_dp.sv
// bfedp_seq_dp: bit-column dot product (signed 8-bit lanes, per-column shift) added to a partial sum, PIPE_LAT register stages deep
module bfedp_seq_dp
    import bfedp_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WCOL_W-1:0] weight_column0,
    input  logic [WCOL_W-1:0] weight_column1,
    input  logic [WCOL_W-1:0] weight_column2,
    input  logic [WCOL_W-1:0] weight_column3,
    input  logic [WCOL_W-1:0] weight_sign,
    input  logic [ACT_W-1:0]  activations,
    input  logic [SHIFT_W-1:0] shift_offset,
    input  logic [PSUM_W-1:0] partial_sum,
    output logic [PSUM_W-1:0] sum_out
);
    logic [WCOL_W-1:0] cols [COLS];
    logic [PSUM_W-1:0] comb_sum, term;
    logic [PSUM_W-1:0] pipe_q [PIPE_LAT];

    assign cols = '{weight_column0, weight_column1, weight_column2, weight_column3};

    // each set bit in column k adds the signed lane activation scaled by 2^shift_k; all sums wrap at 16 bits
    always_comb begin
        comb_sum = partial_sum;
        term = '0;
        for (int k = 0; k < COLS; k++)
            for (int j = 0; j < LANES; j++) begin
                term = {{(PSUM_W-8){activations[8*j+7]}}, activations[8*j +: 8]};
                term = weight_sign[j] ? -term : term;
                term = term << shift_offset[SH_W*k +: SH_W];
                comb_sum = comb_sum + (cols[k][j] ? term : '0);
            end
    end

    // delay line giving the fixed input-to-result latency; flushed by reset
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
        else begin
            pipe_q[0] <= comb_sum;
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end

    assign sum_out = pipe_q[PIPE_LAT-1];
endmodule

// File: rtl/bfedp_seq.sv
// bfedp_seq: sequences cfg_steps operand beats through one bFEDP, accumulating into acc and returning the final sum
module bfedp_seq
    import bfedp_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [STEP_W-1:0]     cfg_steps,
    input  logic [PSUM_W-1:0]     init_psum,
    output logic                  busy,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [COLS*WCOL_W-1:0] op_wcol,
    input  logic [WCOL_W-1:0]     op_wsign,
    input  logic [ACT_W-1:0]      op_act,
    input  logic [SHIFT_W-1:0]    op_shift,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PSUM_W-1:0]     res_data
);
    state_t state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d, step_dec;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [PSUM_W-1:0] acc_q, acc_d, dp_sum;
    logic [COLS*WCOL_W-1:0] wcol_q;
    logic [WCOL_W-1:0] wsign_q;
    logic [ACT_W-1:0] act_q;
    logic [SHIFT_W-1:0] shift_q;
    logic op_fire;

    assign op_fire = state_q == S_FETCH && op_valid;
    assign step_dec = step_q - 1'b1;

    bfedp_seq_dp #(.PIPE_LAT(PIPE_LAT)) u_dp (
        .clk            (clk),
        .rst            (rst),
        .weight_column0 (wcol_q[0*WCOL_W +: WCOL_W]),
        .weight_column1 (wcol_q[1*WCOL_W +: WCOL_W]),
        .weight_column2 (wcol_q[2*WCOL_W +: WCOL_W]),
        .weight_column3 (wcol_q[3*WCOL_W +: WCOL_W]),
        .weight_sign    (wsign_q),
        .activations    (act_q),
        .shift_offset   (shift_q),
        .partial_sum    (acc_q),
        .sum_out        (dp_sum)
    );

    // job FSM: capture job, fetch a beat, wait out the pipeline, fold the result into acc, repeat
    always_comb begin
        state_d = state_q;
        step_d = step_q;
        wait_d = wait_q;
        acc_d = acc_q;
        case (state_q)
            S_IDLE: if (start) begin
                step_d = cfg_steps;
                acc_d = init_psum;
                state_d = cfg_steps != '0 ? S_FETCH : S_DONE;
            end
            S_FETCH: if (op_valid) begin
                wait_d = WAIT_W'(PIPE_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: if (wait_q == '0) begin
                acc_d = dp_sum;
                step_d = step_dec;
                state_d = step_dec != '0 ? S_FETCH : S_DONE;
            end else
                wait_d = wait_q - 1'b1;
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state, counters, accumulator and operand hold registers; hold registers only move on a beat handshake
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            step_q <= '0;
            wait_q <= '0;
            acc_q <= '0;
            wcol_q <= '0;
            wsign_q <= '0;
            act_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            step_q <= step_d;
            wait_q <= wait_d;
            acc_q <= acc_d;
            if (op_fire) begin
                wcol_q <= op_wcol;
                wsign_q <= op_wsign;
                act_q <= op_act;
                shift_q <= op_shift;
            end
        end

    assign busy = state_q != S_IDLE;
    assign op_ready = state_q == S_FETCH;
    assign res_valid = state_q == S_DONE;
    assign res_data = acc_q;
endmodule

// File: tb/tb_bfedp_seq.sv
// tb_bfedp_seq: directed and random jobs with a result scoreboard, timing, stall, backpressure and reset checks
module tb_bfedp_seq;
    localparam int P = 3;
    logic clk = 1'b0;
    logic rst, start, op_valid, op_ready, busy, res_valid, res_ready;
    logic [4:0] cfg_steps;
    logic [15:0] init_psum, res_data;
    logic [31:0] op_wcol;
    logic [7:0] op_wsign;
    logic [63:0] op_act;
    logic [11:0] op_shift;
    logic [31:0] a_wcol [256];
    logic [7:0] a_wsign [256];
    logic [63:0] a_act [256];
    logic [11:0] a_shift [256];
    logic [7:0] idx = '0;
    int hs_edge [256];
    int ec = 0, s_edge = 0, checks = 0, errors = 0, lat = 0, base = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    bfedp_seq #(.PIPE_LAT(P)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_steps(cfg_steps), .init_psum(init_psum),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_wcol(op_wcol),
        .op_wsign(op_wsign), .op_act(op_act), .op_shift(op_shift), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data)
    );

    assign op_wcol = a_wcol[idx];
    assign op_wsign = a_wsign[idx];
    assign op_act = a_act[idx];
    assign op_shift = a_shift[idx];

    always @(posedge clk) begin
        ec <= ec + 1;
        if (op_valid && op_ready) idx <= idx + 1'b1;
    end

    // monitor: record beat handshake edges, check every presented result against the scoreboard head
    always @(negedge clk) begin
        if (op_valid && op_ready) hs_edge[idx] = ec + 1;
        if (res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %0d, required no result", $signed(res_data));
            end else begin
                if (res_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL res_data: got %0d, required %0d", $signed(res_data), $signed(exp_q[0]));
                end
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", n, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [31:0] w, input logic [7:0] s, input logic [63:0] a, input logic [11:0] sh);
        a_wcol[8'(i)] = w;
        a_wsign[8'(i)] = s;
        a_act[8'(i)] = a;
        a_shift[8'(i)] = sh;
    endtask

    task automatic rand_fill(input int b, input int n);
        for (int i = 0; i < n; i++) put(b + i, $urandom, 8'($urandom), {$urandom, $urandom}, 12'($urandom));
    endtask

    // golden model: rebuild each lane's integer weight from its column bits, multiply, sum, then wrap to 16 bits
    function automatic logic [15:0] model(input logic [15:0] init, input int b, input int n);
        int acc, w, p;
        logic [7:0] k;
        acc = int'($signed(init));
        for (int s = 0; s < n; s++) begin
            k = 8'(b + s);
            for (int j = 0; j < 8; j++) begin
                w = 0;
                for (int c = 0; c < 4; c++) if (a_wcol[k][8*c+j]) w += 1 << a_shift[k][3*c +: 3];
                p = int'($signed(a_act[k][8*j +: 8])) * w;
                acc += a_wsign[k][j] ? -p : p;
            end
        end
        return acc[15:0];
    endfunction

    task automatic go(input logic [4:0] n, input logic [15:0] ip);
        cfg_steps = n;
        init_psum = ip;
        start = 1'b1;
        s_edge = ec + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        for (int n = 0; n < 1000 && !res_valid; n++) @(negedge clk);
        l = ec - s_edge;
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got no res_valid, required res_valid within 1000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target);
        for (int n = 0; n < 1000 && int'(idx) != target; n++) cyc(1);
        chk("handshake_reached", int'(idx), target);
    endtask

    task automatic chk_zero_outs(input string n);
        chk({n, "_busy"}, int'(busy), 0);
        chk({n, "_op_ready"}, int'(op_ready), 0);
        chk({n, "_res_valid"}, int'(res_valid), 0);
        chk({n, "_res_data"}, int'(res_data), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required completion before 1 ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op_valid = 1'b0;
        res_ready = 1'b1;
        cfg_steps = '0;
        init_psum = '0;
        @(negedge clk);
        chk_zero_outs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        op_valid = 1'b1;

        base = int'(idx);
        exp_q.push_back(16'd100);
        go(5'd0, 16'd100);
        wait_valid(lat);
        chk("zero_steps_latency", lat, 0);
        chk("zero_steps_handshakes", int'(idx) - base, 0);

        base = int'(idx);
        rand_fill(base, 3);
        for (int i = 0; i < 3; i++) a_wcol[8'(base + i)] = '0;
        exp_q.push_back(16'hFFFB);
        go(5'd3, 16'hFFFB);
        wait_valid(lat);
        chk("zero_wt_latency", lat, 15);
        chk("zero_wt_handshakes", int'(idx) - base, 3);
        chk("zero_wt_hs0_edge", hs_edge[8'(base)] - s_edge, 1);
        chk("zero_wt_hs1_edge", hs_edge[8'(base + 1)] - s_edge, 6);
        chk("zero_wt_hs2_edge", hs_edge[8'(base + 2)] - s_edge, 11);

        base = int'(idx);
        put(base, 32'h0000_0103, 8'h02, 64'h0000_0000_0000_FE03, 12'h010);
        put(base + 1, 32'h0000_0001, 8'h00, 64'h1, 12'h000);
        exp_q.push_back(16'd27);
        go(5'd1, 16'd10);
        wait_valid(lat);
        chk("hand_latency", lat, 5);
        exp_q.push_back(16'h8000);
        go(5'd1, 16'h7FFF);
        wait_valid(lat);
        chk("wrap_back_to_back_latency", lat, 5);

        base = int'(idx);
        rand_fill(base, 31);
        put(base, 32'hFFFF_FFFF, 8'h00, {8{8'h80}}, 12'hFFF);
        exp_q.push_back(model(16'h1234, base, 31));
        go(5'd31, 16'h1234);
        wait_valid(lat);
        chk("random31_latency", lat, 155);

        base = int'(idx);
        rand_fill(base, 3);
        exp_q.push_back(model(16'hFF00, base, 3));
        go(5'd3, 16'hFF00);
        wait_hs(base + 2);
        for (int n = 0; n < 100 && !op_ready; n++) cyc(1);
        op_valid = 1'b0;
        cyc(7);
        op_valid = 1'b1;
        wait_valid(lat);
        chk("stall_latency", lat, 22);

        base = int'(idx);
        rand_fill(base, 2);
        exp_q.push_back(model(16'h0321, base, 2));
        res_ready = 1'b0;
        go(5'd2, 16'h0321);
        wait_valid(lat);
        chk("bp_latency", lat, 10);
        start = 1'b1;
        cfg_steps = 5'd1;
        init_psum = 16'd7;
        cyc(10);
        start = 1'b0;
        chk("bp_hold_valid", int'(res_valid), 1);
        res_ready = 1'b1;
        cyc(1);
        chk("bp_idle_after_handshake", int'(busy), 0);

        base = int'(idx);
        rand_fill(base, 2);
        exp_q.push_back(model(16'hC000, base, 2));
        go(5'd2, 16'hC000);
        cyc(3);
        start = 1'b1;
        cfg_steps = 5'd5;
        init_psum = 16'd999;
        cyc(2);
        start = 1'b0;
        wait_valid(lat);
        chk("busy_start_latency", lat, 10);
        cyc(3);
        chk("busy_start_not_queued", int'(busy), 0);
        chk("busy_start_handshakes", int'(idx) - base, 2);

        base = int'(idx);
        rand_fill(base, 3);
        go(5'd3, 16'h0ABC);
        wait_hs(base + 2);
        cyc(1);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_zero_outs("midjob_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);
        base = int'(idx);
        rand_fill(base, 1);
        exp_q.push_back(model(16'h0042, base, 1));
        go(5'd1, 16'h0042);
        wait_valid(lat);
        chk("post_reset_latency", lat, 5);

        cyc(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
